// File: rtl/m_ucode_seq_pkg.sv
// Shared definitions for the microcode sequencer: sequencing opcodes, default
// entry points and the placement of the sequencing fields in the 48-bit ROM word.
package m_ucode_seq_pkg;

  typedef enum logic [2:0] {
    UC_NEXT     = 3'd0,
    UC_DISPATCH = 3'd1,
    UC_BRANCH   = 3'd2,
    UC_CALL     = 3'd3,
    UC_RETURN   = 3'd4,
    UC_LOOPLD   = 3'd5,
    UC_LOOP     = 3'd6,
    UC_RSVD     = 3'd7
  } uc_ctl_e;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  localparam int          ROM_W         = 48;
  localparam logic [7:0]  BOOT_ADDR_DEF = 8'h00;
  localparam logic [7:0]  TRAP_ADDR_DEF = 8'hF0;

  // d_nxt occupies the low byte, d_ctl sits directly above it
  localparam int NXT_LSB = 0;
  localparam int NXT_MSB = 7;
  localparam int CTL_LSB = 8;
  localparam int CTL_MSB = 10;

  function automatic logic [2:0] rom_ctl(input logic [ROM_W-1:0] word);
    return word[CTL_MSB:CTL_LSB];
  endfunction

  function automatic logic [7:0] rom_nxt(input logic [ROM_W-1:0] word);
    return word[NXT_MSB:NXT_LSB];
  endfunction

endpackage

// File: rtl/m_ucode_seq_if.sv
// Signals between the microcode ROM / datapath and the microsequencer.
// The slave modport is the sequencer's view; master is the ROM/datapath side.
interface m_ucode_seq_if #(
  parameter int AW = 8,
  parameter int CW = 5
);
  logic          stall;
  logic [2:0]    d_ctl;
  logic [AW-1:0] d_nxt;
  logic          cond;
  logic [AW-1:0] dispatch_addr;
  logic [CW-1:0] loop_ld;
  logic          irq;
  logic [AW-1:0] minx;
  logic          progress_ucode;
  logic          irq_ack;
  logic          uerr;
  logic          running;

  modport slave (
    input  stall, d_ctl, d_nxt, cond, dispatch_addr, loop_ld, irq,
    output minx, progress_ucode, irq_ack, uerr, running
  );

  modport master (
    output stall, d_ctl, d_nxt, cond, dispatch_addr, loop_ld, irq,
    input  minx, progress_ucode, irq_ack, uerr, running
  );
endinterface

// File: rtl/m_ucode_seq.sv
// Microsequencer: produces the ROM micro address and read-enable, tracking the
// one-cycle EBR latency so that d_* always describe the word at cur_q.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_RST  | held in reset; RE=0, ROM output not yet valid
// ST_BOOT | one cycle fetching BOOT_ADDR; stall ignored
// ST_RUN  | normal sequencing; RE=~stall, d_* valid for the word at cur_q
module m_ucode_seq
  import m_ucode_seq_pkg::*;
#(
  parameter int            AW        = 8,
  parameter int            CW        = 5,
  parameter logic [AW-1:0] BOOT_ADDR = AW'(BOOT_ADDR_DEF),
  parameter logic [AW-1:0] TRAP_ADDR = AW'(TRAP_ADDR_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  m_ucode_seq_if.slave  bus
);

  seq_state_e    state_q, state_nxt;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] minx;
  logic          re;
  logic          irq_ack;
  logic          uerr;
  logic          running;
  logic [AW-1:0] cur_inc;
  uc_ctl_e       ctl;

  assign ctl     = uc_ctl_e'(bus.d_ctl);
  assign cur_inc = cur_q + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cur_q   <= BOOT_ADDR;
      ret_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cur_q   <= cur_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_nxt = state_q;
    minx      = BOOT_ADDR;
    re        = 1'b0;
    irq_ack   = 1'b0;
    uerr      = 1'b0;
    running   = 1'b0;
    cur_d     = cur_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_RST: begin
        state_nxt = ST_BOOT;
      end

      ST_BOOT: begin
        re        = 1'b1;
        cur_d     = BOOT_ADDR;
        state_nxt = ST_RUN;
      end

      ST_RUN: begin
        running = 1'b1;
        re      = ~bus.stall;
        case (ctl)
          UC_NEXT:     minx = bus.d_nxt;
          UC_DISPATCH: begin
            minx    = bus.irq ? TRAP_ADDR : bus.dispatch_addr;
            irq_ack = bus.irq & ~bus.stall;
          end
          UC_BRANCH:   minx = bus.cond ? bus.d_nxt : cur_inc;
          UC_CALL: begin
            minx = bus.d_nxt;
            if (re) ret_d = cur_inc;
          end
          UC_RETURN:   minx = ret_q;
          UC_LOOPLD: begin
            minx = bus.d_nxt;
            if (re) cnt_d = bus.loop_ld;
          end
          UC_LOOP: begin
            // N in the counter means N re-executions beyond the first pass
            if (cnt_q != '0) begin
              minx = cur_q;
              if (re) cnt_d = cnt_q - CW'(1);
            end else begin
              minx = bus.d_nxt;
            end
          end
          default: begin
            minx = bus.d_nxt;
            uerr = ~bus.stall;
          end
        endcase
        if (re) cur_d = minx;
      end

      default: state_nxt = ST_RST;
    endcase
  end

  assign bus.minx           = minx;
  assign bus.progress_ucode = re;
  assign bus.irq_ack        = irq_ack;
  assign bus.uerr           = uerr;
  assign bus.running        = running;

endmodule

// File: tb/tb_m_ucode_seq.sv
// Directed bench for m_ucode_seq: the bench plays the ROM by driving d_* for
// the word at the committed address and checks address, RE and pulses.
module tb_m_ucode_seq;
  import m_ucode_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  m_ucode_seq_if #(.AW(8), .CW(5)) bus ();

  m_ucode_seq #(.AW(8), .CW(5), .BOOT_ADDR(8'h00), .TRAP_ADDR(8'hF0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [2:0] ctl, input logic [7:0] nxt);
    bus.d_ctl = ctl;
    bus.d_nxt = nxt;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.d_ctl = UC_NEXT; bus.d_nxt = 8'h10; bus.cond = 1'b0;
    bus.dispatch_addr = 8'h00; bus.loop_ld = 5'd0; bus.irq = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.minx !== 8'h00) begin n_bad++; $display("FAIL rst_minx got=%h exp=00", bus.minx); end
    n_cmp++; if (bus.progress_ucode !== 1'b0) begin n_bad++; $display("FAIL rst_re got=%b exp=0", bus.progress_ucode); end
    n_cmp++; if ({bus.running, bus.irq_ack, bus.uerr} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b exp=000", {bus.running, bus.irq_ack, bus.uerr}); end
    n_cmp++; if ({dut.cur_q, dut.ret_q, dut.cnt_q} !== 21'h0) begin n_bad++; $display("FAIL rst_regs got=%h/%h/%h exp=0/0/0", dut.cur_q, dut.ret_q, dut.cnt_q); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.progress_ucode !== 1'b0) begin n_bad++; $display("FAIL rel_re got=%b exp=0", bus.progress_ucode); end
    tick();
    n_cmp++; if (bus.minx !== 8'h00 || bus.progress_ucode !== 1'b1 || bus.running !== 1'b0) begin n_bad++; $display("FAIL boot got minx=%h re=%b run=%b exp 00/1/0", bus.minx, bus.progress_ucode, bus.running); end
    tick();
    n_cmp++; if (bus.running !== 1'b1 || bus.minx !== 8'h10) begin n_bad++; $display("FAIL run_first got run=%b minx=%h exp 1/10", bus.running, bus.minx); end
    n_cmp++; if (dut.cur_q !== 8'h00) begin n_bad++; $display("FAIL run_cur0 got=%h exp=00", dut.cur_q); end
    tick();
    n_cmp++; if (dut.cur_q !== 8'h10) begin n_bad++; $display("FAIL run_cur1 got=%h exp=10", dut.cur_q); end
  endtask

  task automatic test_dispatch();
    bus.dispatch_addr = 8'h42; bus.irq = 1'b0;
    set_word(UC_DISPATCH, 8'h77);
    n_cmp++; if (bus.minx !== 8'h42 || bus.irq_ack !== 1'b0) begin n_bad++; $display("FAIL disp got minx=%h ack=%b exp 42/0", bus.minx, bus.irq_ack); end
    tick();
    n_cmp++; if (dut.cur_q !== 8'h42) begin n_bad++; $display("FAIL disp_cur got=%h exp=42", dut.cur_q); end
    bus.irq = 1'b1;
    set_word(UC_DISPATCH, 8'h77);
    n_cmp++; if (bus.minx !== 8'hF0 || bus.irq_ack !== 1'b1) begin n_bad++; $display("FAIL trap got minx=%h ack=%b exp F0/1", bus.minx, bus.irq_ack); end
    tick();
    set_word(UC_NEXT, 8'hFF);
    n_cmp++; if (dut.cur_q !== 8'hF0 || bus.irq_ack !== 1'b0) begin n_bad++; $display("FAIL trap_after got cur=%h ack=%b exp F0/0", dut.cur_q, bus.irq_ack); end
    bus.irq = 1'b0;
    tick();
  endtask

  task automatic test_branch();
    bus.cond = 1'b0;
    set_word(UC_BRANCH, 8'h30);
    n_cmp++; if (dut.cur_q !== 8'hFF || bus.minx !== 8'h00) begin n_bad++; $display("FAIL br_wrap got cur=%h minx=%h exp FF/00", dut.cur_q, bus.minx); end
    bus.cond = 1'b1;
    #1;
    n_cmp++; if (bus.minx !== 8'h30) begin n_bad++; $display("FAIL br_taken got=%h exp=30", bus.minx); end
    bus.cond = 1'b0;
    #1;
    tick();
    n_cmp++; if (dut.cur_q !== 8'h00) begin n_bad++; $display("FAIL br_cur got=%h exp=00", dut.cur_q); end
    set_word(UC_NEXT, 8'h20);
    tick();
  endtask

  task automatic test_call_return();
    set_word(UC_CALL, 8'h80);
    n_cmp++; if (bus.minx !== 8'h80) begin n_bad++; $display("FAIL call_minx got=%h exp=80", bus.minx); end
    tick();
    n_cmp++; if (dut.ret_q !== 8'h21 || dut.cur_q !== 8'h80) begin n_bad++; $display("FAIL call_regs got ret=%h cur=%h exp 21/80", dut.ret_q, dut.cur_q); end
    set_word(UC_RETURN, 8'h99);
    n_cmp++; if (bus.minx !== 8'h21) begin n_bad++; $display("FAIL ret_minx got=%h exp=21", bus.minx); end
    tick();
    set_word(UC_CALL, 8'h90);
    tick();
    set_word(UC_RETURN, 8'h99);
    n_cmp++; if (bus.minx !== 8'h22) begin n_bad++; $display("FAIL ret2_minx got=%h exp=22", bus.minx); end
    tick();
  endtask

  task automatic test_reserved();
    set_word(UC_RSVD, 8'h40);
    n_cmp++; if (bus.minx !== 8'h40 || bus.uerr !== 1'b1) begin n_bad++; $display("FAIL rsvd got minx=%h uerr=%b exp 40/1", bus.minx, bus.uerr); end
    bus.stall = 1'b1;
    #1;
    n_cmp++; if (bus.uerr !== 1'b0 || bus.progress_ucode !== 1'b0) begin n_bad++; $display("FAIL rsvd_stall got uerr=%b re=%b exp 0/0", bus.uerr, bus.progress_ucode); end
    tick();
    n_cmp++; if (dut.cur_q !== 8'h22) begin n_bad++; $display("FAIL rsvd_hold got=%h exp=22", dut.cur_q); end
    bus.stall = 1'b0;
    tick();
    n_cmp++; if (dut.cur_q !== 8'h40) begin n_bad++; $display("FAIL rsvd_cur got=%h exp=40", dut.cur_q); end
  endtask

  task automatic test_loop();
    logic [4:0] exp_cnt;
    bus.loop_ld = 5'd3;
    set_word(UC_LOOPLD, 8'h50);
    tick();
    n_cmp++; if (dut.cnt_q !== 5'd3 || dut.cur_q !== 8'h50) begin n_bad++; $display("FAIL ld got cnt=%0d cur=%h exp 3/50", dut.cnt_q, dut.cur_q); end
    set_word(UC_LOOP, 8'h60);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.minx !== 8'h50) begin n_bad++; $display("FAIL loop_minx%0d got=%h exp=50", k, bus.minx); end
      tick();
      exp_cnt = 5'(2 - k);
      n_cmp++; if (dut.cnt_q !== exp_cnt) begin n_bad++; $display("FAIL loop_cnt%0d got=%0d exp=%0d", k, dut.cnt_q, exp_cnt); end
    end
    n_cmp++; if (bus.minx !== 8'h60) begin n_bad++; $display("FAIL loop_exit got=%h exp=60", bus.minx); end
    tick();
    n_cmp++; if (dut.cur_q !== 8'h60 || dut.cnt_q !== 5'd0) begin n_bad++; $display("FAIL loop_done got cur=%h cnt=%0d exp 60/0", dut.cur_q, dut.cnt_q); end
  endtask

  task automatic test_stall_reset();
    bus.loop_ld = 5'd2;
    set_word(UC_LOOPLD, 8'h50);
    tick();
    bus.stall = 1'b1; bus.irq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_word((i == 1) ? UC_DISPATCH : (i == 2) ? UC_RSVD : UC_LOOP, 8'h60);
      n_cmp++; if ({bus.progress_ucode, bus.irq_ack, bus.uerr} !== 3'b000) begin n_bad++; $display("FAIL stall%0d got re/ack/uerr=%b exp 000", i, {bus.progress_ucode, bus.irq_ack, bus.uerr}); end
      tick();
      n_cmp++; if (dut.cnt_q !== 5'd2 || dut.cur_q !== 8'h50) begin n_bad++; $display("FAIL stall_hold%0d got cnt=%0d cur=%h exp 2/50", i, dut.cnt_q, dut.cur_q); end
    end
    bus.irq = 1'b0;
    set_word(UC_LOOP, 8'h60);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.minx !== 8'h00 || {bus.progress_ucode, bus.running, bus.irq_ack, bus.uerr} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst got minx=%h flags=%b exp 00/0000", bus.minx, {bus.progress_ucode, bus.running, bus.irq_ack, bus.uerr}); end
    n_cmp++; if ({dut.cur_q, dut.ret_q, dut.cnt_q} !== 21'h0) begin n_bad++; $display("FAIL mid_rst_regs got=%h/%h/%h exp 0/0/0", dut.cur_q, dut.ret_q, dut.cnt_q); end
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    n_cmp++; if (bus.progress_ucode !== 1'b1 || bus.minx !== 8'h00) begin n_bad++; $display("FAIL reboot got re=%b minx=%h exp 1/00", bus.progress_ucode, bus.minx); end
    tick();
    n_cmp++; if (bus.running !== 1'b1 || bus.progress_ucode !== 1'b0 || dut.cur_q !== 8'h00) begin n_bad++; $display("FAIL reboot_run got run=%b re=%b cur=%h exp 1/0/00", bus.running, bus.progress_ucode, dut.cur_q); end
    bus.stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_branch();
    test_call_return();
    test_reserved();
    test_loop();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
